// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution MAC stream: FSM encoding, a clog2 helper,
// and the ReLU/saturation function applied at window close.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Input width is carried in a 64-bit signed container; ow picks the output range.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int ow,
                                                  input logic relu,
                                                  output logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] x;
    x   = (relu && (v < 64'sd0)) ? 64'sd0 : v;
    hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    if (x > hi) begin
      x   = hi;
      sat = 1'b1;
    end else if (x < lo) begin
      x   = lo;
      sat = 1'b1;
    end
    return x;
  endfunction

endpackage

// File: rtl/conv_mac_stream_if.sv
// Streaming handshake bundle between the convolution engine and its producer/consumer.
interface conv_mac_stream_if #(
  parameter int IW = 4,
  parameter int FW = 4,
  parameter int OW = 10
);
  logic                 start;
  logic [IW-1:0]        data_in;
  logic signed [FW-1:0] coef_in;
  logic                 relu_en;
  logic                 read_en;
  logic                 busy;
  logic                 done;
  logic                 result_valid;
  logic signed [OW-1:0] result;
  logic                 result_last;
  logic                 overflow;

  modport master (
    output start, data_in, coef_in, relu_en, read_en,
    input  busy, done, result_valid, result, result_last, overflow
  );

  modport slave (
    input  start, data_in, coef_in, relu_en, read_en,
    output busy, done, result_valid, result, result_last, overflow
  );
endinterface

// File: rtl/conv_result_buf.sv
// NWIN x OW window result store: one write port at window close, one registered read port.
module conv_result_buf
  import cnn_pkg::*;
#(
  parameter int NWIN = 5,
  parameter int OW   = 10,
  localparam int WW  = (NWIN > 1) ? clog2(NWIN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WW-1:0]        wr_addr,
  input  logic signed [OW-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [WW-1:0]        rd_addr,
  input  logic                 rd_last,
  output logic signed [OW-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_last_q
);

  logic signed [OW-1:0] mem [NWIN];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      rd_last_q <= rd_en && rd_last;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_mac_stream.sv
// Serial multiply-accumulate convolution engine: KSIZE taps per window, NWIN windows
// buffered per frame, then drained one result per read.
//
// state   | meaning
// IDLE    | waiting for the first tap of a new frame
// ACC     | accumulating taps, windows closing into the buffer
// FULL    | all windows buffered, draining under read_en
module conv_mac_stream
  import cnn_pkg::*;
#(
  parameter int IW    = 4,
  parameter int FW    = 4,
  parameter int KSIZE = 9,
  parameter int NWIN  = 5,
  parameter int OW    = 10
) (
  input logic               clk,
  input logic               rst_n,
  conv_mac_stream_if.slave  bus
);

  localparam int PW = IW + FW + 1;
  localparam int AW = PW + clog2(KSIZE);
  localparam int TW = (KSIZE > 1) ? clog2(KSIZE) : 1;
  localparam int WW = (NWIN > 1) ? clog2(NWIN) : 1;

  state_t               state;
  state_t               state_next;
  logic signed [AW-1:0] acc;
  logic [TW-1:0]        tap;
  logic [WW-1:0]        win;
  logic [WW-1:0]        rptr;
  logic                 ovf;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [63:0]   sat_val;
  logic                 sat_flag;
  logic signed [OW-1:0] wr_data;
  logic                 consume;
  logic                 close;
  logic                 last_win;
  logic                 rd;
  logic                 last_rd;

  always_comb begin
    prod    = PW'($signed({1'b0, bus.data_in})) * PW'(bus.coef_in);
    sum     = acc + AW'(prod);
    sat_val = sat_relu(64'(sum), OW, bus.relu_en, sat_flag);
    wr_data = OW'(sat_val);
  end

  assign consume  = bus.start && (state != ST_FULL);
  assign close    = consume && (tap == TW'(KSIZE - 1));
  assign last_win = (win == WW'(NWIN - 1));
  assign rd       = (state == ST_FULL) && bus.read_en;
  assign last_rd  = rd && (rptr == WW'(NWIN - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACC: begin
        if (close && last_win) state_next = ST_FULL;
        else if (consume)      state_next = ST_ACC;
      end
      ST_FULL: begin
        if (last_rd) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc  <= '0;
      tap  <= '0;
      win  <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (close) begin
        acc <= '0;
        tap <= '0;
        win <= last_win ? '0 : win + 1'b1;
      end else if (consume) begin
        acc <= sum;
        tap <= tap + 1'b1;
      end
      // The first tap of a frame restarts the sticky flag, even if it also closes a window.
      if (consume && (state == ST_IDLE)) ovf <= close && sat_flag;
      else if (close && sat_flag)        ovf <= 1'b1;
      if (rd) rptr <= last_rd ? '0 : rptr + 1'b1;
    end
  end

  conv_result_buf #(
    .NWIN (NWIN),
    .OW   (OW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (close),
    .wr_addr   (win),
    .wr_data   (wr_data),
    .rd_en     (rd),
    .rd_addr   (rptr),
    .rd_last   (last_rd),
    .rd_data   (bus.result),
    .rd_valid  (bus.result_valid),
    .rd_last_q (bus.result_last)
  );

  assign bus.busy     = (state == ST_ACC);
  assign bus.done     = (state == ST_FULL);
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_conv_mac_stream.sv
// Bench for conv_mac_stream: two instances (OW=10 and OW=6) share one stimulus stream
// and are compared against a window-sum reference model.
module tb_conv_mac_stream;

  localparam int IW    = 4;
  localparam int FW    = 4;
  localparam int KSIZE = 3;
  localparam int NWIN  = 2;
  localparam int OW_A  = 10;
  localparam int OW_B  = 6;
  localparam int NT    = KSIZE * NWIN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       relu_en = 1'b0;
  logic       read_en = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] coef_in = '0;

  always #5 clk = ~clk;

  conv_mac_stream_if #(.IW(IW), .FW(FW), .OW(OW_A)) ifa ();
  conv_mac_stream_if #(.IW(IW), .FW(FW), .OW(OW_B)) ifb ();

  assign ifa.start   = start;
  assign ifa.data_in = data_in;
  assign ifa.coef_in = coef_in;
  assign ifa.relu_en = relu_en;
  assign ifa.read_en = read_en;
  assign ifb.start   = start;
  assign ifb.data_in = data_in;
  assign ifb.coef_in = coef_in;
  assign ifb.relu_en = relu_en;
  assign ifb.read_en = read_en;

  conv_mac_stream #(.IW(IW), .FW(FW), .KSIZE(KSIZE), .NWIN(NWIN), .OW(OW_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  conv_mac_stream #(.IW(IW), .FW(FW), .KSIZE(KSIZE), .NWIN(NWIN), .OW(OW_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int exp_a [NWIN];
  int exp_b [NWIN];
  bit ov_a;
  bit ov_b;

  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a window result is the plain integer dot product, ReLU'd, then clipped.
  function automatic int win_model(input int s, input int ow, input bit relu, output bit ov);
    int v;
    int hi;
    int lo;
    v  = (relu && s < 0) ? 0 : s;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    ov = 0;
    if (v > hi) begin v = hi; ov = 1; end
    else if (v < lo) begin v = lo; ov = 1; end
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " busy_a"},  longint'(ifa.busy), 0);
    chk({tag, " done_a"},  longint'(ifa.done), 0);
    chk({tag, " valid_a"}, longint'(ifa.result_valid), 0);
    chk({tag, " last_a"},  longint'(ifa.result_last), 0);
    chk({tag, " ovf_a"},   longint'(ifa.overflow), 0);
    chk({tag, " res_a"},   longint'(ifa.result), 0);
    chk({tag, " busy_b"},  longint'(ifb.busy), 0);
    chk({tag, " done_b"},  longint'(ifb.done), 0);
    chk({tag, " valid_b"}, longint'(ifb.result_valid), 0);
    chk({tag, " last_b"},  longint'(ifb.result_last), 0);
    chk({tag, " ovf_b"},   longint'(ifb.overflow), 0);
    chk({tag, " res_b"},   longint'(ifb.result), 0);
  endtask

  task automatic run_frame(input string tag, input int d[NT], input int c[NT], input bit relu,
                           input int stall_at, input int stall_len, input int gap_max);
    bit o;
    ov_a = 0;
    ov_b = 0;
    for (int w = 0; w < NWIN; w++) begin
      int s;
      s = 0;
      for (int k = 0; k < KSIZE; k++) s += d[w*KSIZE+k] * c[w*KSIZE+k];
      exp_a[w] = win_model(s, OW_A, relu, o);
      ov_a |= o;
      exp_b[w] = win_model(s, OW_B, relu, o);
      ov_b |= o;
    end
    relu_en = relu;
    for (int t = 0; t < NT; t++) begin
      start   = 1'b1;
      data_in = 4'(d[t]);
      coef_in = 4'(c[t]);
      tick();
      start = 1'b0;
      if (t == 0) begin
        chk({tag, " first-tap busy"},  longint'(ifa.busy), 1);
        chk({tag, " first-tap ovf_a"}, longint'(ifa.overflow), 0);
        chk({tag, " first-tap ovf_b"}, longint'(ifb.overflow), 0);
      end
      if (t == stall_at && t != NT - 1) begin
        repeat (stall_len) begin
          data_in = 4'($urandom);
          coef_in = 4'($urandom);
          tick();
          chk({tag, " stall busy"}, longint'(ifb.busy), 1);
          chk({tag, " stall done"}, longint'(ifb.done), 0);
        end
      end
      if (t != NT - 1) begin
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end
    chk({tag, " full done_a"}, longint'(ifa.done), 1);
    chk({tag, " full done_b"}, longint'(ifb.done), 1);
    chk({tag, " full busy"},   longint'(ifa.busy), 0);
    chk({tag, " full ovf_a"},  longint'(ifa.overflow), longint'(ov_a));
    chk({tag, " full ovf_b"},  longint'(ifb.overflow), longint'(ov_b));
  endtask

  task automatic drain(input string tag, input bit with_start, input int gap_max);
    if (with_start) begin
      start   = 1'b1;
      data_in = 4'd7;
      coef_in = 4'd3;
      tick();
      chk({tag, " start-in-full done"}, longint'(ifa.done), 1);
      chk({tag, " start-in-full busy"}, longint'(ifa.busy), 0);
    end
    for (int w = 0; w < NWIN; w++) begin
      repeat ($urandom_range(0, gap_max)) begin
        tick();
        chk({tag, " gap valid"}, longint'(ifa.result_valid), 0);
        if (w > 0) chk({tag, " gap hold"}, longint'(ifa.result), longint'(exp_a[w-1]));
      end
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      chk({tag, " valid_a"}, longint'(ifa.result_valid), 1);
      chk({tag, " valid_b"}, longint'(ifb.result_valid), 1);
      chk({tag, " res_a"},   longint'(ifa.result), longint'(exp_a[w]));
      chk({tag, " res_b"},   longint'(ifb.result), longint'(exp_b[w]));
      chk({tag, " last"},    longint'(ifa.result_last), (w == NWIN - 1) ? 1 : 0);
      chk({tag, " done"},    longint'(ifa.done), (w == NWIN - 1) ? 0 : 1);
      chk({tag, " ovf_b"},   longint'(ifb.overflow), longint'(ov_b));
    end
    start = 1'b0;
    tick();
    chk({tag, " post valid"}, longint'(ifa.result_valid), 0);
    chk({tag, " post busy"},  longint'(ifa.busy), 0);
    chk({tag, " post hold"},  longint'(ifb.result), longint'(exp_b[NWIN-1]));
  endtask

  int d1 [NT] = '{1, 2, 3, 2, 3, 4};
  int c1 [NT] = '{1, 2, 3, -3, -2, -1};
  int ds [NT] = '{15, 15, 15, 15, 15, 15};
  int cs [NT] = '{7, 7, 7, 7, 7, 7};

  initial begin
    int dr [NT];
    int cr [NT];
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b0;
    tick();

    run_frame("basic", d1, c1, 1'b0, -1, 0, 0);
    chk("basic exp0", longint'(exp_a[0]), 14);
    drain("basic", 1'b0, 0);

    run_frame("relu", d1, c1, 1'b1, -1, 0, 0);
    drain("relu", 1'b0, 0);

    run_frame("sat", ds, cs, 1'b0, -1, 0, 0);
    drain("sat", 1'b0, 1);
    chk("sat sticky ovf_b", longint'(ifb.overflow), 1);

    run_frame("stall", d1, c1, 1'b0, 1, 3, 0);
    drain("stall", 1'b1, 0);

    read_en = 1'b1;
    tick();
    chk("idle read valid", longint'(ifa.result_valid), 0);
    tick();
    chk("idle read valid2", longint'(ifb.result_valid), 0);
    chk("idle read done", longint'(ifa.done), 0);
    read_en = 1'b0;

    for (int t = 0; t < 4; t++) begin
      start   = 1'b1;
      data_in = 4'd9;
      coef_in = 4'd5;
      tick();
    end
    start = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    run_frame("postreset", d1, c1, 1'b0, -1, 0, 0);
    drain("postreset", 1'b0, 0);

    for (int f = 0; f < 20; f++) begin
      for (int t = 0; t < NT; t++) begin
        dr[t] = int'($urandom_range(0, 15));
        cr[t] = int'($urandom_range(0, 15)) - 8;
      end
      run_frame("rand", dr, cr, 1'($urandom), int'($urandom_range(0, NT - 1)),
                int'($urandom_range(0, 3)), 2);
      drain("rand", 1'($urandom), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
